// File: rtl/clk_pkg.sv
// clk_pkg: shared FSM state encoding and default parameters for clk_monitor
package clk_pkg;
  typedef enum logic {WAIT_FIRST = 1'b0, MEASURE = 1'b1} state_t;
  localparam int unsigned DEF_CNT_W = 32;
  localparam int unsigned DEF_STALL_LIMIT = 32'h0100_0000;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer (clk, rst async high, d async in, q = second flop)
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic s0;
  always_ff @(posedge clk or posedge rst)
    if (rst) {s0, q} <= 2'b00;
    else {s0, q} <= {d, s0};
endmodule

// File: rtl/clk_monitor.sv
// clk_monitor: samples a slow clock on clk, emits rise/fall strobes, measures period/high time, flags stall (ports: clk, rst, sig_in -> rise_pulse, fall_pulse, period, high_time, meas_upd, period_valid, stalled, rise_count)
module clk_monitor
  import clk_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned STALL_LIMIT = DEF_STALL_LIMIT,
  parameter int unsigned EVT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_upd,
  output logic             period_valid,
  output logic             stalled,
  output logic [EVT_W-1:0] rise_count
);
  localparam logic [CNT_W-1:0] LIM_M1 = CNT_W'(STALL_LIMIT - 1);
  logic s1, s2;
  logic [CNT_W-1:0] cnt, hi_cap;
  state_t state;
  logic rise_det, fall_det, stall_hit;
  sync_2ff u_sync (.clk(clk), .rst(rst), .d(sig_in), .q(s1));
  assign rise_det  = s1 & ~s2;
  assign fall_det  = ~s1 & s2;
  assign stall_hit = ~stalled & (cnt == LIM_M1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s2           <= 1'b0;
      cnt          <= '0;
      hi_cap       <= '0;
      state        <= WAIT_FIRST;
      rise_pulse   <= 1'b0;
      fall_pulse   <= 1'b0;
      period       <= '0;
      high_time    <= '0;
      meas_upd     <= 1'b0;
      period_valid <= 1'b0;
      stalled      <= 1'b0;
      rise_count   <= '0;
    end else begin
      s2         <= s1;
      rise_pulse <= rise_det;
      fall_pulse <= fall_det;
      meas_upd   <= 1'b0;
      if (rise_det) rise_count <= rise_count + 1'b1;
      if (rise_det) cnt <= '0;
      else if (!stalled && cnt != '1) cnt <= cnt + 1'b1;
      if (fall_det && state == MEASURE) hi_cap <= cnt + 1'b1;
      if (rise_det) begin
        stalled <= 1'b0;
        state   <= MEASURE;
        if (state == MEASURE) begin
          period       <= cnt + 1'b1;
          high_time    <= hi_cap;
          meas_upd     <= 1'b1;
          period_valid <= 1'b1;
        end
      end else if (stall_hit) begin
        stalled      <= 1'b1;
        period_valid <= 1'b0;
        period       <= '0;
        high_time    <= '0;
        state        <= WAIT_FIRST;
      end
    end
endmodule

// File: tb/tb_clk_monitor.sv
// tb_clk_monitor: directed stimulus with an edge-timestamp reference model checked every cycle
module tb_clk_monitor;
  localparam int L = 64;
  logic clk = 1'b0, rst = 1'b1, sig_in = 1'b0;
  logic rise_pulse, fall_pulse, meas_upd, period_valid, stalled;
  logic [31:0] period, high_time;
  logic [3:0] rise_count;
  int ncmp = 0, nerr = 0;

  clk_monitor #(.CNT_W(32), .STALL_LIMIT(L), .EVT_W(4)) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .period(period), .high_time(high_time),
    .meas_upd(meas_upd), .period_valid(period_valid),
    .stalled(stalled), .rise_count(rise_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: events are timestamped by edge number since reset;
  // sampled input shows up as a strobe two edges later.
  int e, ref_e, hicap, m_per, m_hi, m_rc;
  bit h0, h1, h2, armed, m_valid, m_stall, m_rise, m_fall, m_upd;
  always @(posedge clk or posedge rst)
    if (rst) begin
      e = 0; ref_e = 0; hicap = 0; m_per = 0; m_hi = 0; m_rc = 0;
      {h0, h1, h2, armed, m_valid, m_stall, m_rise, m_fall, m_upd} = '0;
    end else begin
      e++;
      m_rise = h1 & ~h2;
      m_fall = ~h1 & h2;
      m_upd  = 0;
      {h2, h1, h0} = {h1, h0, sig_in};
      if (m_rise) begin
        m_rc = (m_rc + 1) % 16;
        if (armed) begin
          m_per = e - ref_e; m_hi = hicap; m_upd = 1; m_valid = 1;
        end
        armed = 1; m_stall = 0; ref_e = e;
      end else if (!m_stall && e - ref_e == L) begin
        m_stall = 1; m_valid = 0; m_per = 0; m_hi = 0; armed = 0;
      end
      if (m_fall && armed) hicap = e - ref_e;
    end

  always @(negedge clk)
    if (!rst) begin
      chk("rise_pulse", 32'(rise_pulse), 32'(m_rise));
      chk("fall_pulse", 32'(fall_pulse), 32'(m_fall));
      chk("meas_upd", 32'(meas_upd), 32'(m_upd));
      chk("period_valid", 32'(period_valid), 32'(m_valid));
      chk("stalled", 32'(stalled), 32'(m_stall));
      chk("period", period, 32'(m_per));
      chk("high_time", high_time, 32'(m_hi));
      chk("rise_count", 32'(rise_count), 32'(m_rc));
    end

  task automatic hold(input logic v, input int n);
    sig_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic sq(input int hi, input int lo, input int n);
    repeat (n) begin
      hold(1'b1, hi);
      hold(1'b0, lo);
    end
  endtask

  task automatic all_zero(input string nm);
    chk({nm, "_out"}, {24'(0), rise_pulse, fall_pulse, meas_upd, period_valid, stalled, 3'b0}, 32'd0);
    chk({nm, "_period"}, period, 32'd0);
    chk({nm, "_high"}, high_time, 32'd0);
    chk({nm, "_rc"}, 32'(rise_count), 32'd0);
  endtask

  task automatic async_reset(input string nm);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 all_zero(nm);
    sig_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    all_zero("reset");
    rst = 1'b0;
    hold(1'b0, 2);
    hold(1'b1, 2);
    chk("rise_lat_early", 32'(rise_pulse), 32'd0);
    hold(1'b1, 1);
    chk("rise_lat_2", 32'(rise_pulse), 32'd1);
    chk("first_rise_no_upd", 32'(period_valid), 32'd0);
    hold(1'b1, 1);
    hold(1'b0, 4);
    sq(4, 4, 5);
    chk("sq_period", period, 32'd8);
    chk("sq_high", high_time, 32'd4);
    chk("sq_valid", 32'(period_valid), 32'd1);
    sq(3, 13, 3);
    chk("duty_period", period, 32'd16);
    chk("duty_high", high_time, 32'd3);
    hold(1'b1, 3);
    chk("stall_anchor_rise", 32'(rise_pulse), 32'd1);
    hold(1'b0, 63);
    chk("stall_not_yet", 32'(stalled), 32'd0);
    hold(1'b0, 1);
    chk("stall_set", 32'(stalled), 32'd1);
    chk("stall_valid", 32'(period_valid), 32'd0);
    chk("stall_period", period, 32'd0);
    hold(1'b0, 10);
    chk("stall_held", 32'(stalled), 32'd1);
    sq(4, 4, 1);
    chk("stall_clear", 32'(stalled), 32'd0);
    chk("stall_first_nopub", 32'(period_valid), 32'd0);
    sq(4, 4, 1);
    chk("stall_republish", period, 32'd8);
    hold(1'b0, 56);
    hold(1'b1, 3);
    chk("coinc_period", period, 32'd64);
    chk("coinc_nostall", 32'(stalled), 32'd0);
    hold(1'b1, 1);
    hold(1'b0, 4);
    sq(4, 4, 3);
    chk("pre_reset_period", period, 32'd8);
    hold(1'b1, 2);
    async_reset("mid_meas");
    sq(4, 4, 1);
    chk("post_reset_nopub", 32'(period_valid), 32'd0);
    async_reset("pre_wrap");
    sq(2, 2, 17);
    hold(1'b0, 3);
    chk("rc_wrap", 32'(rise_count), 32'd1);
    chk("rc_period", period, 32'd4);
    hold(1'b1, 1);
    async_reset("mid_stream");
    hold(1'b0, 4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/clk_monitor.md
# clk_monitor

Fast-domain observer for the divided CPU clock. Samples a slow clock-like input (Clk_CPU, or any clkdiv bit) on the board clock and synchronizes it. Emits single-cycle rise/fall strobes and measures period and high time in board-clock cycles. Flags a stalled clock. Feeds the debug display and the single-step logic, which must never use the divided clock as a clock.

## Interface
Parameters:
- CNT_W, 32, width of the cycle counter and of the measurement outputs.
- STALL_LIMIT, 32'h0100_0000, number of cycles without a rise before the clock is declared stalled. Must satisfy 2 < STALL_LIMIT < 2^CNT_W − 1.
- EVT_W, 16, width of the rise-event counter.

Ports:
- clk  in  1  board clock; all logic on its posedge.
- rst  in  1  reset, asynchronous and active-high.
- sig_in  in  1  monitored slow clock; asynchronous to clk.
- rise_pulse  out  1  one-cycle strobe per detected rising edge.
- fall_pulse  out  1  one-cycle strobe per detected falling edge.
- period  out  CNT_W  clk cycles between the last two rise events.
- high_time  out  CNT_W  clk cycles from the rise to the fall within that period.
- meas_upd  out  1  one-cycle strobe when period/high_time are updated.
- period_valid  out  1  level; period/high_time hold a valid measurement.
- stalled  out  1  level; no rise seen for STALL_LIMIT cycles.
- rise_count  out  EVT_W  count of rise events; wraps.

## Operation
- Synchronizer: s0 ← sig_in, s1 ← s0, s2 ← s1.
  - rise_det = s1 & ~s2.
  - fall_det = ~s1 & s2.
  - The two are mutually exclusive.
- Cycle counter cnt:
  - Cleared on rise_det.
  - Otherwise increments by 1, saturating at 2^CNT_W − 1.
  - Holds while stalled = 1.
- FSM has 2 states, WAIT_FIRST and MEASURE.
  - WAIT_FIRST:
    - On rise_det: cnt ← 0, go to MEASURE. Nothing is published.
    - On fall_det: fall_pulse is still emitted; no capture.
  - MEASURE:
    - On fall_det: hi_cap ← cnt + 1.
    - On rise_det: period ← cnt + 1, high_time ← hi_cap, meas_upd = 1, period_valid ← 1.
- Stall:
  - Condition: the cycle where cnt = STALL_LIMIT − 1 with no rise_det, in either state.
  - Action: stalled ← 1, period_valid ← 0, period ← 0, high_time ← 0, go to WAIT_FIRST.
  - The next rise_det clears stalled and is treated as a first rise (no publish).
- Simultaneous stall condition and rise_det: the rise wins. No stall is declared; the normal rise action applies.
- rise_count increments on every rise_det, in both states and while stalled. Wraps 2^EVT_W − 1 → 0.
- Reset (any time, including mid-measurement): every output, cnt, hi_cap and the sync flops go to 0, and the FSM goes to WAIT_FIRST.
- sig_in pulses shorter than one clk period may be missed. This is accepted behaviour.

## Timing
- sig_in is sampled high at edge k:
  - rise_det is true during cycle k+1..k+2.
  - rise_pulse, meas_upd and the new period/high_time are registered at edge k+2 and visible from k+2.
  - Input-to-strobe latency is 2 clk cycles. Falls have the same latency.
- All outputs are registered. Strobes are high for exactly one cycle.
- For a periodic sig_in with period P and high time H (integer clk cycles, P ≥ 2):
  - Every rise after the first yields period = P and high_time = H.
  - The first meas_upd occurs on the second rise.
- Stall assertion comes STALL_LIMIT cycles after the last rise_det (or after reset if no rise has occurred).

## Structure
- Shared package/header clk_pkg holds:
  - state encoding (WAIT_FIRST = 1'b0, MEASURE = 1'b1);
  - default STALL_LIMIT;
  - CNT_W default.
- The synchronizer is one sub-module, sync_2ff (2-flop, async active-high reset to 0). It is instantiated once; s2 and the edge detect live in clk_monitor.

## Test plan
- Reset mid-measurement: assert rst while MEASURE holds period = 8 -> all outputs read 0 immediately (async), the FSM is in WAIT_FIRST, and the first rise after release does not pulse meas_upd.
- Square wave 4 high / 4 low -> first meas_upd at the 2nd rise; then every 8 cycles period = 8, high_time = 4, period_valid = 1; rise_pulse exactly 2 cycles after sig_in goes high.
- Duty change to 3 high / 13 low -> the next update after the change gives period = 16, high_time = 3.
- Stall: STALL_LIMIT = 64 and sig_in held low after a rise -> stalled = 1 and period_valid = 0 exactly 64 cycles after that rise_det, with period = 0 and cnt frozen. The next two rises clear stalled, then publish.
- Rise coinciding with the stall threshold: rise_det on the cycle cnt = STALL_LIMIT − 1 -> stalled stays 0 and period = STALL_LIMIT.
- rise_count wrap: EVT_W = 4 and 17 rises -> rise_count = 1. Also rst asserted mid-stream returns all outputs to 0 asynchronously.
